// File: rtl/threshold_ctrl.sv
// threshold_ctrl: debounced up/down/select buttons editing per-channel saturating thresholds, plus a registered sample compare

// Per-button synchroniser and press FSM; emits a one-cycle event on acceptance and on auto-repeat
module threshold_btn #(
  parameter int DEB_CNT    = 999_999,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic evt_o
);
  localparam int M1   = (DEB_CNT > REPEAT_DLY) ? DEB_CNT : REPEAT_DLY;
  localparam int CMAX = (M1 > REPEAT_PER) ? M1 : REPEAT_PER;
  localparam int TW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic [TW-1:0] cnt_q, rel_q, lim;
  logic evt_q;
  // Held-time limit: first repeat after REPEAT_DLY, later ones every REPEAT_PER
  assign lim = (state_q == HELD) ? TW'(REPEAT_DLY - 1) : TW'(REPEAT_PER - 1);
  assign evt_o = evt_q;
  // Synchronise the raw button and walk the press FSM; cnt_q counts pressed cycles, rel_q released ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      rel_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      evt_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (!sync_q[1]) begin
            state_q <= DEBOUNCE;
            cnt_q   <= TW'(1);
          end
        DEBOUNCE:
          if (sync_q[1]) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == TW'(DEB_CNT - 1)) begin
            evt_q   <= 1'b1;
            state_q <= HELD;
            cnt_q   <= '0;
            rel_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        default:
          if (sync_q[1]) begin
            if (rel_q == TW'(DEB_CNT - 1)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              rel_q   <= '0;
            end else rel_q <= rel_q + 1'b1;
          end else begin
            rel_q <= '0;
            if (REPEAT_EN) begin
              if (cnt_q == lim) begin
                evt_q   <= 1'b1;
                state_q <= REPEAT;
                cnt_q   <= '0;
              end else cnt_q <= cnt_q + 1'b1;
            end
          end
      endcase
    end
endmodule

module threshold_ctrl #(
  parameter int WIDTH      = 16,
  parameter int NCH        = 4,
  parameter int MAX_VAL    = 'h7fff,
  parameter int MIN_VAL    = 'h0000,
  parameter int STEP       = 'h05b0,
  parameter int DEB_CNT    = 999_999,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_sel,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     sample,
  input  logic [CW-1:0]        sample_ch,
  output logic [NCH*WIDTH-1:0] line,
  output logic [CW-1:0]        sel_ch,
  output logic                 changed,
  output logic                 hit,
  output logic [CW-1:0]        hit_ch
);
  localparam logic [2**CW-1:0] CH_OK = {(2**CW){1'b1}} >> (2**CW - NCH);
  logic up_evt, dn_evt, sel_evt;
  logic [NCH-1:0][WIDTH-1:0] line_q, line_d;
  logic [CW-1:0] sel_q, sel_d, hit_ch_q;
  logic changed_q, hit_q, ch_ok;
  logic [WIDTH-1:0] cur, nxt_up, nxt_dn, new_v;
  logic [WIDTH:0] up_sum;
  logic signed [WIDTH:0] dn_dif;
  threshold_btn #(.DEB_CNT(DEB_CNT), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_up (.clk(clk), .rst_n(rst_n), .btn_i(btn_up), .evt_o(up_evt));
  threshold_btn #(.DEB_CNT(DEB_CNT), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1))
    u_dn (.clk(clk), .rst_n(rst_n), .btn_i(btn_down), .evt_o(dn_evt));
  threshold_btn #(.DEB_CNT(DEB_CNT), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0))
    u_sel (.clk(clk), .rst_n(rst_n), .btn_i(btn_sel), .evt_o(sel_evt));
  assign cur    = line_q[sel_q];
  assign up_sum = {1'b0, cur} + (WIDTH+1)'(STEP);
  assign dn_dif = $signed({1'b0, cur}) - $signed((WIDTH+1)'(STEP));
  assign nxt_up = (up_sum > (WIDTH+1)'(MAX_VAL)) ? WIDTH'(MAX_VAL) : up_sum[WIDTH-1:0];
  assign nxt_dn = (dn_dif < $signed((WIDTH+1)'(MIN_VAL))) ? WIDTH'(MIN_VAL) : dn_dif[WIDTH-1:0];
  assign new_v  = (up_evt && !dn_evt) ? nxt_up : (dn_evt && !up_evt) ? nxt_dn : cur;
  assign sel_d  = sel_evt ? ((sel_q == CW'(NCH - 1)) ? '0 : sel_q + 1'b1) : sel_q;
  assign ch_ok  = sample_valid && CH_OK[sample_ch];
  assign line    = line_q;
  assign sel_ch  = sel_q;
  assign changed = changed_q;
  assign hit     = hit_q;
  assign hit_ch  = hit_ch_q;
  // Only the channel selected before this cycle's select event takes the step
  always_comb begin
    line_d = line_q;
    line_d[sel_q] = new_v;
  end
  // Threshold, selection and compare registers; compare sees the pre-step threshold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_q    <= {NCH{WIDTH'(MIN_VAL)}};
      sel_q     <= '0;
      changed_q <= 1'b0;
      hit_q     <= 1'b0;
      hit_ch_q  <= '0;
    end else begin
      line_q    <= line_d;
      sel_q     <= sel_d;
      changed_q <= new_v != cur;
      hit_q     <= ch_ok && (sample > line_q[sample_ch]);
      hit_ch_q  <= ch_ok ? sample_ch : hit_ch_q;
    end
endmodule

// File: doc/threshold_ctrl.md
THRESHOLD_CTRL -- requirements
Module: threshold_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning threshold and sample width in bits.
REQ-002 SHALL have parameter NCH, default 4, meaning number of independent threshold channels (1..16).
REQ-003 SHALL have parameter MAX_VAL, default 'h7fff, meaning upper clamp of every threshold.
REQ-004 SHALL have parameter MIN_VAL, default 'h0000, meaning lower clamp and reset value of every threshold.
REQ-005 SHALL have parameter STEP, default 'h05b0, meaning increment/decrement per step event.
REQ-006 SHALL have parameter DEB_CNT, default 999_999, meaning cycles a raw button must be stable before acceptance.
REQ-007 SHALL have parameter REPEAT_DLY, default 25_000_000, meaning held cycles after acceptance before auto-repeat starts.
REQ-008 SHALL have parameter REPEAT_PER, default 5_000_000, meaning cycles between auto-repeat events.
REQ-009 SHALL have port clk input 1, meaning system clock; all logic on its rising edge.
REQ-010 SHALL have port rst_n input 1, meaning reset, asynchronous, active-low.
REQ-011 SHALL have ports btn_up, btn_down, btn_sel input 1, meaning raw asynchronous buttons, active-low (pressed = 0).
REQ-012 SHALL have port sample_valid input 1, meaning sample qualifier.
REQ-013 SHALL have port sample input WIDTH, meaning unsigned value to compare.
REQ-014 SHALL have port sample_ch input CW = max(1,$clog2(NCH)), meaning channel of sample.
REQ-015 SHALL have port line output NCH*WIDTH, meaning channel k threshold at bits [k*WIDTH +: WIDTH], registered.
REQ-016 SHALL have port sel_ch output CW, meaning channel currently edited by up/down, registered.
REQ-017 SHALL have port changed output 1, meaning one-cycle pulse when any threshold value actually changes.
REQ-018 SHALL have ports hit output 1, hit_ch output CW, meaning registered compare result and its channel.

Function
REQ-019 Each button SHALL pass a 2-flop synchroniser, then a per-button FSM: IDLE, DEBOUNCE, HELD, REPEAT.
REQ-020 IDLE->DEBOUNCE on synchronised 0; DEBOUNCE returns to IDLE on any 1 before DEB_CNT consecutive 0s; on reaching DEB_CNT emits one event and enters HELD.
REQ-021 HELD: after REPEAT_DLY further held cycles emits one event and enters REPEAT; REPEAT emits one event every REPEAT_PER cycles.
REQ-022 HELD/REPEAT SHALL return to IDLE after DEB_CNT consecutive released (1) cycles; release shorter than DEB_CNT is ignored; no event on release.
REQ-023 btn_sel SHALL use debounce only (no auto-repeat); each event advances sel_ch by 1, wrapping NCH-1 -> 0.
REQ-024 Up event: line[sel_ch] <= min(line+STEP, MAX_VAL), computed in WIDTH+1 bits, saturating (no wrap).
REQ-025 Down event: line[sel_ch] <= max(line-STEP, MIN_VAL), computed in WIDTH+1 bits signed, saturating.
REQ-026 Up and down events in the same cycle SHALL cancel: no change, changed = 0.
REQ-027 Step and sel events in the same cycle: step applies to the sel_ch value before the update.
REQ-028 changed SHALL pulse the cycle after the line register updates to a different value; no pulse when already clamped.
REQ-029 Compare: when sample_valid and sample_ch < NCH, next cycle hit = (sample > line[sample_ch]), hit_ch = sample_ch; otherwise hit = 0, hit_ch holds.
REQ-030 Compare SHALL use line value registered at the sampling cycle (pre-update if a step occurs same cycle); latency exactly 1 cycle.

Reset
REQ-031 On rst_n low all line channels SHALL be MIN_VAL, sel_ch = 0, changed = 0, hit = 0, hit_ch = 0, all FSMs IDLE, counters 0, synchronisers 1.
REQ-032 Reset mid-press SHALL discard pending events; after release of reset a held button requires full DEB_CNT before its event.

Verification (DEB_CNT=4, REPEAT_DLY=20, REPEAT_PER=8, NCH=4)
REQ-033 btn_up low 10 cycles -> line[0] 0x0000 -> 0x05b0 once, changed one pulse; line[1..3] stay 0.
REQ-034 btn_up bounce (low 3, high 1, repeated) then low 40 -> exactly 1 + 1 + 2 steps (initial, REPEAT_DLY, two REPEAT_PER) = 0x16c0.
REQ-035 Repeated up on ch0 from 0x7a50 -> clamps at 0x7fff, no further changed pulse; repeated down from 0x0400 -> 0x0000.
REQ-036 btn_sel pressed 5 times -> sel_ch 0,1,2,3,0,1; up then applies to ch1 only.
REQ-037 btn_up and btn_down accepted same cycle -> no change; sample=0x05b1, ch0 with line[0]=0x05b0 -> hit=1 next cycle; sample_ch=4 (NCH=4, CW=2 unreachable; use NCH=3, sample_ch=3) -> hit=0.
REQ-038 rst_n asserted during REPEAT -> all outputs reset values immediately; button still low after release -> first step only after 4+2 cycles.
